// File: rtl/fxp_normalizer_pipe.sv
// Two-stage fixed-point normaliser: sign/magnitude split, then leading-zero count
// and left normalisation, on a valid/ready stream with full backpressure.
module fxp_normalizer_pipe #(
    parameter int C_FXP_WIDTH = 32,
    parameter int C_SIGNED    = 1,
    parameter int C_LZC_WIDTH = $clog2(C_FXP_WIDTH + 1)
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [C_FXP_WIDTH-1:0] S_DATA,
    input  logic                   S_VALID,
    output logic                   S_READY,
    output logic [C_FXP_WIDTH-1:0] M_MANT,
    output logic [C_LZC_WIDTH-1:0] M_LZC,
    output logic                   M_SIGN,
    output logic                   M_ZERO,
    output logic                   M_VALID,
    input  logic                   M_READY
);

    localparam int W   = C_FXP_WIDTH;
    localparam int NN  = (W + 3) / 4;
    localparam int NW  = NN * 4;
    localparam int PAD = NW - W;

    logic                   w_ready1;
    logic                   w_ready2;
    logic                   w_sign_in;
    logic [W-1:0]           w_mag_in;
    logic [NW-1:0]          w_pad;
    logic                   w_nib_nz [NN];
    logic [1:0]             w_nib_lz [NN];
    logic [C_LZC_WIDTH-1:0] w_lzc;
    logic [W-1:0]           w_mant;
    logic                   w_zero;

    logic                   r_v1;
    logic                   r_sign1;
    logic [W-1:0]           r_mag1;
    logic                   r_v2;
    logic [W-1:0]           r_mant2;
    logic [C_LZC_WIDTH-1:0] r_lzc2;
    logic                   r_sign2;
    logic                   r_zero2;

    assign w_ready2 = ~r_v2 | M_READY;
    assign w_ready1 = ~r_v1 | w_ready2;
    assign S_READY  = w_ready1 & ARESETN;

    generate
        if (C_SIGNED != 0) begin : g_signed
            // Most-negative input negates to itself, which is the correct unsigned magnitude.
            assign w_sign_in = S_DATA[W-1];
            assign w_mag_in  = w_sign_in ? (~S_DATA) + W'(1) : S_DATA;
        end else begin : g_unsigned
            assign w_sign_in = 1'b0;
            assign w_mag_in  = S_DATA;
        end
    endgenerate

    // Zero-fill at the LSB end so the nibble grid lines up with the MSB.
    assign w_pad = NW'(r_mag1) << PAD;

    genvar gi;
    generate
        for (gi = 0; gi < NN; gi++) begin : g_nib
            logic [3:0] w_n;
            assign w_n          = w_pad[NW-1-4*gi -: 4];
            assign w_nib_nz[gi] = |w_n;
            assign w_nib_lz[gi] = w_n[3] ? 2'd0 :
                                  w_n[2] ? 2'd1 :
                                  w_n[1] ? 2'd2 : 2'd3;
        end
    endgenerate

    // Scan from the least significant nibble so the most significant non-zero one wins.
    always_comb begin
        w_lzc = C_LZC_WIDTH'(W);
        for (int k = NN - 1; k >= 0; k--) begin
            if (w_nib_nz[k]) begin
                w_lzc = C_LZC_WIDTH'(4 * k) + C_LZC_WIDTH'(w_nib_lz[k]);
            end
        end
    end

    assign w_zero = ~|r_mag1;
    assign w_mant = w_zero ? '0 : (r_mag1 << w_lzc);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_v1    <= 1'b0;
            r_sign1 <= 1'b0;
            r_mag1  <= '0;
            r_v2    <= 1'b0;
            r_mant2 <= '0;
            r_lzc2  <= '0;
            r_sign2 <= 1'b0;
            r_zero2 <= 1'b0;
        end else begin
            if (w_ready1) begin
                r_v1    <= S_VALID;
                r_sign1 <= w_sign_in;
                r_mag1  <= w_mag_in;
            end
            if (w_ready2) begin
                r_v2    <= r_v1;
                r_mant2 <= w_mant;
                r_lzc2  <= w_lzc;
                r_sign2 <= r_sign1;
                r_zero2 <= w_zero;
            end
        end
    end

    assign M_VALID = r_v2;
    assign M_MANT  = r_mant2;
    assign M_LZC   = r_lzc2;
    assign M_SIGN  = r_sign2;
    assign M_ZERO  = r_zero2;

endmodule

// File: tb/tb_fxp_normalizer_pipe.sv
// Bench for fxp_normalizer_pipe: four instances (16 signed, 20 unsigned, 13 signed/unsigned)
// checked against an arithmetic reference model.
module tb_fxp_normalizer_pipe;

    typedef struct packed {
        logic [31:0] mant;
        logic [31:0] lzc;
        logic        sign;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] d16, mm16;
    logic [4:0]  ml16;
    logic        sv16 = 0, sr16, ms16, mz16, mv16, mr16 = 1;
    logic [19:0] d20, mm20;
    logic [4:0]  ml20;
    logic        sv20 = 0, sr20, ms20, mz20, mv20, mr20 = 1;
    logic [12:0] da, mma;
    logic [3:0]  mla;
    logic        sva = 0, sra, msa, mza, mva, mra = 1;
    logic [12:0] db, mmb;
    logic [3:0]  mlb;
    logic        svb = 0, srb, msb, mzb, mvb, mrb = 1;

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t act, exp_r;
    res_t qa[$];
    res_t qb[$];

    fxp_normalizer_pipe #(.C_FXP_WIDTH(16), .C_SIGNED(1)) u16 (
        .ACLK(clk), .ARESETN(rst_n), .S_DATA(d16), .S_VALID(sv16), .S_READY(sr16),
        .M_MANT(mm16), .M_LZC(ml16), .M_SIGN(ms16), .M_ZERO(mz16), .M_VALID(mv16), .M_READY(mr16));
    fxp_normalizer_pipe #(.C_FXP_WIDTH(20), .C_SIGNED(0)) u20 (
        .ACLK(clk), .ARESETN(rst_n), .S_DATA(d20), .S_VALID(sv20), .S_READY(sr20),
        .M_MANT(mm20), .M_LZC(ml20), .M_SIGN(ms20), .M_ZERO(mz20), .M_VALID(mv20), .M_READY(mr20));
    fxp_normalizer_pipe #(.C_FXP_WIDTH(13), .C_SIGNED(1)) u13s (
        .ACLK(clk), .ARESETN(rst_n), .S_DATA(da), .S_VALID(sva), .S_READY(sra),
        .M_MANT(mma), .M_LZC(mla), .M_SIGN(msa), .M_ZERO(mza), .M_VALID(mva), .M_READY(mra));
    fxp_normalizer_pipe #(.C_FXP_WIDTH(13), .C_SIGNED(0)) u13u (
        .ACLK(clk), .ARESETN(rst_n), .S_DATA(db), .S_VALID(svb), .S_READY(srb),
        .M_MANT(mmb), .M_LZC(mlb), .M_SIGN(msb), .M_ZERO(mzb), .M_VALID(mvb), .M_READY(mrb));

    // Reference: magnitude from modular arithmetic, LZC from the bit length of the magnitude.
    function automatic res_t model(int w, bit sgn, longint unsigned x);
        res_t r;
        longint unsigned full, xx, mag;
        int lz;
        full   = 64'd1 << w;
        xx     = x % full;
        r.sign = sgn && (xx >= full / 2);
        mag    = r.sign ? full - xx : xx;
        lz     = (mag == 0) ? w : w - $clog2(mag + 1);
        r.lzc  = 32'(lz);
        r.mant = 32'((mag << lz) % full);
        r.zero = (mag == 0);
        return r;
    endfunction

    function automatic res_t pack16();
        return '{32'(mm16), 32'(ml16), ms16, mz16};
    endfunction
    function automatic res_t pack20();
        return '{32'(mm20), 32'(ml20), ms20, mz20};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        act = pack16();
        if (act !== '0 || mv16 !== 1'b0) $display("FAIL reset_outputs: got %h valid %b required 0", act, mv16);
        else n_pass++;
        n_checks++;
        if (sr16 !== 1'b0 || sr20 !== 1'b0) $display("FAIL reset_ready: got %b/%b required 0", sr16, sr20);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (sr16 !== 1'b1 || sra !== 1'b1) $display("FAIL release_ready: got %b/%b required 1", sr16, sra);
        else n_pass++;
    endtask

    task automatic test_directed16();
        logic [15:0] vals [5];
        vals = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0000, 16'h00F0};
        mr16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            sv16 = 1'b1;
            d16  = vals[i];
            #1;
            n_checks++;
            if (sr16 !== 1'b1) $display("FAIL dir16_ready[%0d]: got %b required 1", i, sr16);
            else n_pass++;
            tick();
            sv16 = 1'b0;
            n_checks++;
            if (mv16 !== 1'b0) $display("FAIL dir16_early[%0d]: valid %b required 0", i, mv16);
            else n_pass++;
            tick();
            act   = pack16();
            exp_r = model(16, 1'b1, 64'(vals[i]));
            n_checks++;
            if (mv16 !== 1'b1 || act !== exp_r)
                $display("FAIL dir16[%h]: valid %b got %h required %h", vals[i], mv16, act, exp_r);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_unsigned20();
        logic [19:0] vals [3];
        vals = '{20'hFFFFF, 20'h00003, 20'h00000};
        for (int i = 0; i < 3; i++) begin
            tick();
            sv20 = 1'b1;
            d20  = vals[i];
            tick();
            sv20 = 1'b0;
            tick();
            act   = pack20();
            exp_r = model(20, 1'b0, 64'(vals[i]));
            n_checks++;
            if (mv20 !== 1'b1 || act !== exp_r)
                $display("FAIL u20[%h]: valid %b got %h required %h", vals[i], mv20, act, exp_r);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        mr16 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            sv16 = (k < 16);
            d16  = 16'(k + 1);
            #1;
            if (k < 16) begin
                n_checks++;
                if (sr16 !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b required 1", k, sr16);
                else n_pass++;
            end
            n_checks++;
            if (mv16 !== (k >= 2 && k <= 17)) $display("FAIL b2b_valid[%0d]: got %b", k, mv16);
            else n_pass++;
            if (mv16 === 1'b1) begin
                act   = pack16();
                exp_r = model(16, 1'b1, 64'(k - 1));
                n_checks++;
                if (act !== exp_r) $display("FAIL b2b_data[%0d]: got %h required %h", k, act, exp_r);
                else n_pass++;
            end
        end
        sv16 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] b [4];
        int acc, outn;
        for (int i = 0; i < 4; i++) b[i] = 16'($urandom);
        acc  = 0;
        outn = 0;
        mr16 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            sv16 = (acc < 4);
            d16  = b[acc < 4 ? acc : 0];
            #1;
            act   = pack16();
            exp_r = model(16, 1'b1, 64'(b[0]));
            n_checks++;
            if (c >= 2 && (mv16 !== 1'b1 || act !== exp_r))
                $display("FAIL bp_hold[%0d]: valid %b got %h required %h", c, mv16, act, exp_r);
            else if (c < 2 && mv16 !== 1'b0)
                $display("FAIL bp_hold[%0d]: valid %b required 0", c, mv16);
            else n_pass++;
            if (sv16 && sr16) acc++;
        end
        n_checks++;
        if (acc != 2 || sr16 !== 1'b0) $display("FAIL bp_accept: accepted %0d ready %b required 2/0", acc, sr16);
        else n_pass++;
        for (int c = 0; c < 12; c++) begin
            tick();
            mr16 = 1'b1;
            sv16 = (acc < 4);
            d16  = b[acc < 4 ? acc : 0];
            #1;
            if (mv16 && mr16) begin
                act = pack16();
                n_checks++;
                if (outn >= 4) $display("FAIL bp_extra: got %h required none", act);
                else begin
                    exp_r = model(16, 1'b1, 64'(b[outn]));
                    if (act !== exp_r) $display("FAIL bp_order[%0d]: got %h required %h", outn, act, exp_r);
                    else n_pass++;
                end
                outn++;
            end
            if (sv16 && sr16) acc++;
        end
        sv16 = 1'b0;
        n_checks++;
        if (outn != 4) $display("FAIL bp_count: got %0d beats required 4", outn);
        else n_pass++;
    endtask

    task automatic test_random13();
        for (int n = 0; n < 10000; n++) begin
            tick();
            sva = ($urandom_range(0, 9) < 7);
            svb = ($urandom_range(0, 9) < 7);
            mra = ($urandom_range(0, 9) < 7);
            mrb = ($urandom_range(0, 9) < 6);
            da  = 13'($urandom);
            db  = 13'($urandom);
            #1;
            if (sva && sra) qa.push_back(model(13, 1'b1, 64'(da)));
            if (svb && srb) qb.push_back(model(13, 1'b0, 64'(db)));
            if (mva && mra) begin
                act = '{32'(mma), 32'(mla), msa, mza};
                n_checks++;
                if (qa.size() == 0) $display("FAIL rnd13s_extra: got %h required none", act);
                else begin
                    exp_r = qa.pop_front();
                    if (act !== exp_r) $display("FAIL rnd13s[%0d]: got %h required %h", n, act, exp_r);
                    else n_pass++;
                end
            end
            if (mvb && mrb) begin
                act = '{32'(mmb), 32'(mlb), msb, mzb};
                n_checks++;
                if (qb.size() == 0) $display("FAIL rnd13u_extra: got %h required none", act);
                else begin
                    exp_r = qb.pop_front();
                    if (act !== exp_r) $display("FAIL rnd13u[%0d]: got %h required %h", n, act, exp_r);
                    else n_pass++;
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            tick();
            sva = 1'b0; svb = 1'b0; mra = 1'b1; mrb = 1'b1;
            #1;
            if (mva && qa.size() > 0) begin
                act   = '{32'(mma), 32'(mla), msa, mza};
                exp_r = qa.pop_front();
                n_checks++;
                if (act !== exp_r) $display("FAIL rnd13s_drain: got %h required %h", act, exp_r);
                else n_pass++;
            end
            if (mvb && qb.size() > 0) begin
                act   = '{32'(mmb), 32'(mlb), msb, mzb};
                exp_r = qb.pop_front();
                n_checks++;
                if (act !== exp_r) $display("FAIL rnd13u_drain: got %h required %h", act, exp_r);
                else n_pass++;
            end
        end
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0)
            $display("FAIL rnd13_lost: %0d/%0d beats outstanding required 0", qa.size(), qb.size());
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        mr16 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            sv16 = 1'b1;
            d16  = 16'($urandom_range(1, 65535));
        end
        tick();
        n_checks++;
        if (mv16 !== 1'b1 || sr16 !== 1'b0) $display("FAIL mid_full: valid %b ready %b required 1/0", mv16, sr16);
        else n_pass++;
        rst_n = 1'b0;
        sv16  = 1'b0;
        #1;
        act = pack16();
        n_checks++;
        if (act !== '0 || mv16 !== 1'b0 || sr16 !== 1'b0)
            $display("FAIL mid_reset: got %h valid %b ready %b required 0", act, mv16, sr16);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        mr16  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (mv16 !== 1'b0 || sr16 !== 1'b1)
                $display("FAIL mid_stale[%0d]: valid %b ready %b required 0/1", c, mv16, sr16);
            else n_pass++;
        end
    endtask

    initial begin
        d16 = '0; d20 = '0; da = '0; db = '0;
        test_reset();
        test_directed16();
        test_unsigned20();
        test_back_to_back();
        test_backpressure();
        test_random13();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
